// File: rtl/key_filter_multi.sv
// Multi-channel key debouncer with long-press detection and auto-repeat.
// Each channel has its own synchroniser, debounce FSM, hold counter and repeat counter.

module key_filter_chan #(
  parameter int CNT_MAX   = 999_999,
  parameter int LONG_MAX  = 49_999_999,
  parameter int REP_MAX   = 9_999_999,
  parameter int REPEAT_EN = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic key_raw,
  output logic flag,
  output logic level,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam int RW = $clog2(REP_MAX + 1);

  localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
  localparam logic [LW-1:0] LONG_TOP = LW'(LONG_MAX);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_MAX - 1);
  localparam logic [RW-1:0] REP_TOP  = RW'(REP_MAX);
  localparam bit            REP_ON   = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JITTER0 = 2'd1,
    DOWN    = 2'd2,
    JITTER1 = 2'd3
  } state_t;

  logic [1:0]    sync_r;
  logic          synced_s;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [LW-1:0] hold_r, hold_s;
  logic [RW-1:0] rcnt_r, rcnt_s;
  logic          flag_r, flag_s;
  logic          level_r, level_s;
  logic          long_r, long_s;
  logic          rep_r, rep_s;

  assign synced_s     = sync_r[1];
  assign flag         = flag_r;
  assign level        = level_r;
  assign long_press   = long_r;
  assign repeat_pulse = rep_r;

  // Two-flop synchroniser; idles at the released level so a held key is seen as a fresh press
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_raw};
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      hold_r  <= '0;
      rcnt_r  <= '0;
      flag_r  <= 1'b0;
      level_r <= 1'b1;
      long_r  <= 1'b0;
      rep_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      hold_r  <= hold_s;
      rcnt_r  <= rcnt_s;
      flag_r  <= flag_s;
      level_r <= level_s;
      long_r  <= long_s;
      rep_r   <= rep_s;
    end
  end

  // Next-state, counter updates and output pulses
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    hold_s  = hold_r;
    rcnt_s  = rcnt_r;
    flag_s  = 1'b0;
    level_s = level_r;
    long_s  = 1'b0;
    rep_s   = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s  = '0;
        hold_s = '0;
        rcnt_s = '0;
        if (!synced_s) begin
          state_s = JITTER0;
        end else begin
          state_s = IDLE;
        end
      end
      JITTER0: begin
        hold_s = '0;
        rcnt_s = '0;
        if (synced_s) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == CNT_TOP) begin
          state_s = DOWN;
          cnt_s   = '0;
          flag_s  = 1'b1;
          level_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DOWN: begin
        cnt_s = '0;
        if (synced_s) begin
          state_s = JITTER1;
        end else begin
          state_s = DOWN;
        end
        // Hold counter saturates at LONG_TOP; repeat counter only runs once saturated
        if (hold_r != LONG_TOP) begin
          hold_s = hold_r + LW'(1);
          long_s = (hold_r == LONG_PRE);
        end else if (REP_ON) begin
          if (rcnt_r == REP_TOP) begin
            rcnt_s = '0;
            rep_s  = 1'b1;
          end else begin
            rcnt_s = rcnt_r + RW'(1);
          end
        end else begin
          rcnt_s = '0;
        end
      end
      JITTER1: begin
        if (!synced_s) begin
          state_s = DOWN;
          cnt_s   = '0;
        end else if (cnt_r == CNT_TOP) begin
          state_s = IDLE;
          cnt_s   = '0;
          flag_s  = 1'b1;
          level_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
        hold_s  = '0;
        rcnt_s  = '0;
        level_s = 1'b1;
      end
    endcase
  end

endmodule

module key_filter_multi #(
  parameter int NUM_KEYS  = 4,
  parameter int CNT_MAX   = 999_999,
  parameter int LONG_MAX  = 49_999_999,
  parameter int REP_MAX   = 9_999_999,
  parameter int REPEAT_EN = 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_flag,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_rpt
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_filter_chan #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX),
      .REP_MAX  (REP_MAX),
      .REPEAT_EN(REPEAT_EN)
    ) u_chan (
      .clk         (clk),
      .rstn        (rstn),
      .key_raw     (key_in[g]),
      .flag        (key_flag[g]),
      .level       (key_state[g]),
      .long_press  (key_long[g]),
      .repeat_pulse(key_rpt[g])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Randomised and directed bench for key_filter_multi against a run-length behavioural model.
// Two instances share the stimulus: one with auto-repeat enabled, one without.

module tb_key_filter_multi;

  localparam int NK = 4;
  localparam int CM = 9;
  localparam int LM = 49;
  localparam int RM = 19;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NK-1:0] key_in;
  logic [NK-1:0] flag_a, state_a, long_a, rpt_a;
  logic [NK-1:0] flag_b, state_b, long_b, rpt_b;
  logic [31:0]   obs_w;
  logic [31:0]   exp_v;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: debounced level, length of disagreeing run, press time
  logic m_s1[NK], m_s2[NK], m_level[NK];
  int   m_run[NK], m_hold[NK], m_rep[NK];
  logic [NK-1:0] e_flag, e_state, e_long, e_rpt;

  always #5 clk = ~clk;

  key_filter_multi #(.NUM_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM), .REP_MAX(RM), .REPEAT_EN(1)) dut_a (
    .clk(clk), .rstn(rstn), .key_in(key_in),
    .key_flag(flag_a), .key_state(state_a), .key_long(long_a), .key_rpt(rpt_a)
  );

  key_filter_multi #(.NUM_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM), .REP_MAX(RM), .REPEAT_EN(0)) dut_b (
    .clk(clk), .rstn(rstn), .key_in(key_in),
    .key_flag(flag_b), .key_state(state_b), .key_long(long_b), .key_rpt(rpt_b)
  );

  assign obs_w = {flag_a, state_a, long_a, rpt_a, flag_b, state_b, long_b, rpt_b};

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_level[i] = 1'b1;
      m_run[i] = 0; m_hold[i] = 0; m_rep[i] = 0;
    end
    e_flag = '0; e_state = '1; e_long = '0; e_rpt = '0;
    exp_v = {e_flag, e_state, e_long, e_rpt, e_flag, e_state, e_long, 4'b0000};
  endtask

  // A level change is accepted after CM+2 consecutive synced samples disagree with it
  task automatic model_edge(input logic [NK-1:0] k);
    logic syn;
    for (int i = 0; i < NK; i++) begin
      syn = m_s2[i];
      e_flag[i] = 1'b0; e_long[i] = 1'b0; e_rpt[i] = 1'b0;
      if (m_level[i]) begin
        m_hold[i] = 0; m_rep[i] = 0;
      end else if (m_run[i] == 0) begin
        if (m_hold[i] < LM) begin
          m_hold[i]++;
          if (m_hold[i] == LM) e_long[i] = 1'b1;
        end else begin
          m_rep[i]++;
          if (m_rep[i] == RM + 1) begin
            e_rpt[i] = 1'b1;
            m_rep[i] = 0;
          end
        end
      end
      if (syn != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == CM + 2) begin
          m_level[i] = syn;
          m_run[i] = 0;
          e_flag[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      e_state[i] = m_level[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = k[i];
    end
    exp_v = {e_flag, e_state, e_long, e_rpt, e_flag, e_state, e_long, 4'b0000};
  endtask

  task automatic tick(input logic [NK-1:0] k);
    key_in = k;
    @(posedge clk);
    if (!rstn) model_reset();
    else model_edge(k);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    key_in = 4'b1010;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick(4'b1010);
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL reset t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(4'b1111);
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL reset_idle t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
  endtask

  task automatic test_clean_press();
    int flag_t = -1;
    for (int i = 0; i < 50; i++) begin
      tick(i < 30 ? 4'b1110 : 4'b1111);
      if (flag_a[0] && flag_t < 0) flag_t = i;
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL clean_press t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    vectors++;
    if (flag_t !== CM + 3) begin
      miscompares++;
      $display("FAIL clean_press_latency got=%0d exp=%0d", flag_t, CM + 3);
    end
  endtask

  task automatic test_bounce();
    int n_flag = 0;
    int flag_t = -1;
    logic [NK-1:0] k;
    for (int i = 0; i < 30; i++) begin
      k = (i < 5 || i >= 8) ? 4'b1101 : 4'b1111;
      tick(k);
      if (flag_a[1]) begin
        n_flag++;
        if (flag_t < 0) flag_t = i;
      end
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL bounce t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    vectors++;
    if (n_flag !== 1 || flag_t !== 8 + CM + 3) begin
      miscompares++;
      $display("FAIL bounce_pulse got=%0d@%0d exp=1@%0d", n_flag, flag_t, 8 + CM + 3);
    end
    for (int i = 0; i < 20; i++) begin
      tick(4'b1111);
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL bounce_release t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
  endtask

  task automatic test_long_repeat();
    int n_long_a = 0, n_rpt_a = 0, n_long_b = 0, n_rpt_b = 0, n_flag = 0;
    int long_t = -1;
    for (int i = 0; i < 145; i++) begin
      tick(i < 120 ? 4'b1011 : 4'b1111);
      if (long_a[2]) begin
        n_long_a++;
        if (long_t < 0) long_t = i;
      end
      if (rpt_a[2]) n_rpt_a++;
      if (long_b[2]) n_long_b++;
      if (rpt_b != 4'b0000) n_rpt_b++;
      if (flag_a[2]) n_flag++;
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL long_repeat t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    vectors++;
    if (n_long_a !== 1 || long_t !== CM + 3 + LM || n_rpt_a !== 3 || n_flag !== 2) begin
      miscompares++;
      $display("FAIL long_repeat_counts got long=%0d@%0d rpt=%0d flag=%0d exp long=1@%0d rpt=3 flag=2",
               n_long_a, long_t, n_rpt_a, n_flag, CM + 3 + LM);
    end
    vectors++;
    if (n_long_b !== 1 || n_rpt_b !== 0) begin
      miscompares++;
      $display("FAIL no_repeat_counts got long=%0d rpt=%0d exp long=1 rpt=0", n_long_b, n_rpt_b);
    end
  endtask

  task automatic test_reset_mid_hold();
    int n_long = 0;
    for (int i = 0; i < 42; i++) begin
      tick(4'b0111);
      if (long_a != 4'b0000 || long_b != 4'b0000) n_long++;
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL mid_hold t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs_w !== exp_v) begin
      miscompares++;
      $display("FAIL async_reset got=%h exp=%h", obs_w, exp_v);
    end
    for (int i = 0; i < 3; i++) tick(4'b0111);
    rstn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(i < 40 ? 4'b0111 : 4'b1111);
      if (long_a != 4'b0000 || long_b != 4'b0000) n_long++;
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL held_through_reset t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    vectors++;
    if (n_long !== 0) begin
      miscompares++;
      $display("FAIL mid_hold_long got=%0d exp=0", n_long);
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] f12, f13, s13;
    for (int i = 0; i < 40; i++) begin
      tick(i < 20 ? 4'b0000 : 4'b1111);
      if (i == CM + 3) f12 = flag_a;
      if (i == CM + 4) begin
        f13 = flag_a;
        s13 = state_a;
      end
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL simultaneous t=%0d got=%h exp=%h", i, obs_w, exp_v);
      end
    end
    vectors++;
    if (f12 !== 4'b1111 || f13 !== 4'b0000 || s13 !== 4'b0000) begin
      miscompares++;
      $display("FAIL simultaneous_flags got=%b/%b/%b exp=1111/0000/0000", f12, f13, s13);
    end
  endtask

  task automatic test_random();
    int rem[NK];
    logic [NK-1:0] cur = 4'b1111;
    for (int i = 0; i < NK; i++) rem[i] = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NK; i++) begin
        if (rem[i] == 0) begin
          cur[i] = ~cur[i];
          case ($urandom_range(0, 2))
            0: rem[i] = int'($urandom_range(1, 4));
            1: rem[i] = int'($urandom_range(8, 16));
            default: rem[i] = int'($urandom_range(55, 140));
          endcase
        end
        rem[i]--;
      end
      tick(t < 2970 ? cur : 4'b1111);
      vectors++;
      if (obs_w !== exp_v) begin
        miscompares++;
        $display("FAIL random t=%0d key=%b got=%h exp=%h", t, cur, obs_w, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
